iomem_dbg_master: RTL and testbench



---
 rtl/iomem_dbg_pkg.sv | 29 ++
 rtl/iomem_dbg_txq.sv | 49 ++++
 rtl/iomem_dbg_master.sv | 167 ++++++++++++++++
 tb/tb_iomem_dbg_master.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iomem_dbg_pkg.sv
// Shared types and constants for the byte-stream iomem debug master.
// Holds the FSM state encoding, command/status bytes and response sizing.
package iomem_dbg_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_DATA = 3'd2,
    S_BUS  = 3'd3,
    S_RESP = 3'd4
  } state_e;

  localparam logic [7:0] CMD_WR = 8'h57;
  localparam logic [7:0] CMD_RD = 8'h52;

  localparam logic [7:0] ST_OK  = 8'h4B;
  localparam logic [7:0] ST_TO  = 8'h45;
  localparam logic [7:0] ST_BAD = 8'h3F;

  localparam int RSP_BYTES = 5;
  localparam int RSP_W     = 8 * RSP_BYTES;
  localparam int LEN_W     = 3;

  // Writes and rejected commands answer with a status byte only; reads add 4 data bytes.
  function automatic logic [LEN_W-1:0] rsp_len(input logic is_wr);
    return is_wr ? LEN_W'(1) : LEN_W'(RSP_BYTES);
  endfunction

endpackage

// File: rtl/iomem_dbg_txq.sv
// Response buffer: loads up to 5 bytes in parallel and shifts them out MSB first
// over a valid/ready byte interface.
module iomem_dbg_txq
  import iomem_dbg_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  input  logic             load,
  input  logic [RSP_W-1:0] load_word,
  input  logic [LEN_W-1:0] load_len,
  output logic             tx_valid,
  output logic [7:0]       tx_data,
  input  logic             tx_ready,
  output logic             last_done
);

  logic [RSP_W-1:0] sh_q, sh_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             fire;

  assign tx_valid  = (len_q != '0);
  assign tx_data   = sh_q[RSP_W-1 -: 8];
  assign fire      = tx_valid && tx_ready;
  assign last_done = fire && (len_q == LEN_W'(1));

  // Zeros shift in behind the last byte, so tx_data idles at 0.
  always_comb begin
    sh_d  = sh_q;
    len_d = len_q;
    if (load) begin
      sh_d  = load_word;
      len_d = load_len;
    end else if (fire) begin
      sh_d  = {sh_q[RSP_W-9:0], 8'h00};
      len_d = len_q - LEN_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sh_q  <= '0;
      len_q <= '0;
    end else begin
      sh_q  <= sh_d;
      len_q <= len_d;
    end
  end

endmodule

// File: rtl/iomem_dbg_master.sv
// Host byte stream to iomem initiator: parses 'W'/'R' commands, runs one
// 32-bit bus cycle with timeout, and returns status/data bytes.
//
// state  | meaning
// IDLE   | waiting for a command byte
// ADDR   | collecting 4 address bytes, MSB first
// DATA   | collecting 4 write-data bytes, MSB first
// BUS    | m_valid high, waiting for m_ready or timeout
// RESP   | draining the response buffer to the host
module iomem_dbg_master
  import iomem_dbg_pkg::*;
#(
  parameter int TIMEOUT = 1024,
  parameter int TO_W    = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [3:0]  m_wstrb,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  output logic        busy
);

  localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT > 0) ? TO_W'(TIMEOUT - 1) : '0;

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;

  logic              rx_fire;
  logic              to_expire;
  logic              txq_load;
  logic [RSP_W-1:0]  txq_word;
  logic [LEN_W-1:0]  txq_len;
  logic              tx_done;

  assign rx_fire = rx_valid && rx_ready;
  // Fires on the cycle whose stall would bring the count up to TIMEOUT.
  assign to_expire = (TIMEOUT != 0) && (to_cnt_q == TO_LAST);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      to_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      to_cnt_q <= to_cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    to_cnt_d = to_cnt_q;
    txq_load = 1'b0;
    txq_word = '0;
    txq_len  = '0;
    case (state_q)
      S_IDLE: begin
        if (rx_fire) begin
          if (rx_data == CMD_WR || rx_data == CMD_RD) begin
            wr_d    = (rx_data == CMD_WR);
            cnt_d   = '0;
            state_d = S_ADDR;
          end else begin
            txq_load = 1'b1;
            txq_word = {ST_BAD, 32'h0};
            txq_len  = rsp_len(1'b1);
            state_d  = S_RESP;
          end
        end
      end
      S_ADDR: begin
        if (rx_fire) begin
          addr_d = {addr_q[23:0], rx_data};
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            to_cnt_d = '0;
            state_d  = wr_q ? S_DATA : S_BUS;
          end
        end
      end
      S_DATA: begin
        if (rx_fire) begin
          wdata_d = {wdata_q[23:0], rx_data};
          cnt_d   = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            to_cnt_d = '0;
            state_d  = S_BUS;
          end
        end
      end
      S_BUS: begin
        // m_ready has priority over a timeout landing on the same cycle.
        if (m_ready) begin
          txq_load = 1'b1;
          txq_word = {ST_OK, (wr_q ? 32'h0 : m_rdata)};
          txq_len  = rsp_len(wr_q);
          state_d  = S_RESP;
        end else if (to_expire) begin
          txq_load = 1'b1;
          txq_word = {ST_TO, 32'h0};
          txq_len  = rsp_len(wr_q);
          state_d  = S_RESP;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        if (tx_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // rx_ready is gated by resetn so no byte is consumed while reset is held.
  always_comb begin
    rx_ready = 1'b0;
    m_valid  = 1'b0;
    busy     = (state_q != S_IDLE);
    m_wstrb  = wr_q ? 4'hF : 4'h0;
    case (state_q)
      S_IDLE, S_ADDR, S_DATA: rx_ready = resetn;
      S_BUS:                  m_valid  = 1'b1;
      default:                rx_ready = 1'b0;
    endcase
  end

  assign m_addr  = addr_q;
  assign m_wdata = wdata_q;

  iomem_dbg_txq u_txq (
    .clk       (clk),
    .resetn    (resetn),
    .load      (txq_load),
    .load_word (txq_word),
    .load_len  (txq_len),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .last_done (tx_done)
  );

endmodule

// File: tb/tb_iomem_dbg_master.sv
// Self-checking bench for iomem_dbg_master: a table of command vectors plus
// hand-written sequences for latency, back-pressure, reset and back-to-back cases.
module tb_iomem_dbg_master;

  localparam int TIMEOUT = 8;
  localparam int NV      = 9;
  localparam int LIM     = 200;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [3:0]  m_wstrb;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata = 32'h0;
  logic        busy;

  always #5 clk = ~clk;

  iomem_dbg_master #(.TIMEOUT(TIMEOUT), .TO_W(16)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_ready (rx_ready),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_wstrb  (m_wstrb),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_rdata  (m_rdata),
    .busy     (busy)
  );

  typedef struct {
    int          nb;
    logic [71:0] cmd;
    int          wait_c;
    logic [31:0] rdata;
    int          exp_pulses;
    int          exp_vcyc;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_wstrb;
    bit          chk_wdata;
    int          exp_ntx;
    logic [39:0] exp_tx;
  } vec_t;

  vec_t vecs[NV];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_edge = 0;

  // Responder model state.
  int          rsp_wait = 0;
  logic [31:0] rsp_data = 32'h0;
  int          vcnt = 0;
  int          stab_err = 0;
  logic [31:0] cur_a, cur_w;
  logic [3:0]  cur_s;
  logic [31:0] pa[$];
  logic [31:0] pw[$];
  logic [3:0]  ps[$];
  int          pc[$];

  logic [7:0]  txb[$];
  int          txe[$];

  always @(posedge clk) cyc++;

  // iomem responder: m_ready in the (rsp_wait+1)-th cycle of m_valid; -1 = never.
  always @(posedge clk) begin
    #1;
    if (m_valid) begin
      if (vcnt == 0) begin
        cur_a = m_addr;
        cur_w = m_wdata;
        cur_s = m_wstrb;
      end else if (m_addr !== cur_a || m_wdata !== cur_w || m_wstrb !== cur_s) begin
        stab_err++;
      end
      m_ready = (rsp_wait >= 0) && (vcnt == rsp_wait);
      m_rdata = m_ready ? rsp_data : 32'h0BAD0BAD;
      vcnt++;
    end else begin
      if (vcnt > 0) begin
        pa.push_back(cur_a);
        pw.push_back(cur_w);
        ps.push_back(cur_s);
        pc.push_back(vcnt);
      end
      vcnt    = 0;
      m_ready = 1'b0;
      m_rdata = 32'h0;
    end
  end

  // Host sink: records each byte handshaken on the following rising edge.
  always @(negedge clk) begin
    if (tx_valid && tx_ready) begin
      txb.push_back(tx_data);
      txe.push_back(cyc + 1);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit hold);
    int n;
    n = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && n < LIM) begin
      step();
      n++;
    end
    chk("rx_accept_wait", 64'(rx_ready), 64'(1'b1));
    @(posedge clk);
    #2;
    acc_edge = cyc;
    if (!hold) rx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 300) begin
      step();
      n++;
    end
    chk("idle_wait", 64'(busy), 64'(1'b0));
  endtask

  task automatic clear_logs();
    pa.delete();
    pw.delete();
    ps.delete();
    pc.delete();
    txb.delete();
    txe.delete();
    stab_err = 0;
  endtask

  function automatic vec_t mk(int nb, logic [71:0] cmd, int w, logic [31:0] rd, int np, int vc,
                              logic [31:0] a, logic [31:0] wd, logic [3:0] s, bit cw,
                              int ntx, logic [39:0] tx);
    vec_t v;
    v.nb = nb; v.cmd = cmd; v.wait_c = w; v.rdata = rd;
    v.exp_pulses = np; v.exp_vcyc = vc; v.exp_addr = a; v.exp_wdata = wd;
    v.exp_wstrb = s; v.chk_wdata = cw; v.exp_ntx = ntx; v.exp_tx = tx;
    return v;
  endfunction

  initial begin
    vecs[0] = mk(9, 72'h57_0300_0000_0000_00A5, 1, 32'h0, 1, 2, 32'h0300_0000, 32'h0000_00A5, 4'hF, 1, 1, 40'h4B_0000_0000);
    vecs[1] = mk(5, {40'h52_0300_0000, 32'h0}, 3, 32'hDEAD_BEEF, 1, 4, 32'h0300_0000, 32'h0, 4'h0, 0, 5, 40'h4B_DEAD_BEEF);
    vecs[2] = mk(5, {40'h52_1000_0004, 32'h0}, -1, 32'h0, 1, 8, 32'h1000_0004, 32'h0, 4'h0, 0, 5, 40'h45_0000_0000);
    vecs[3] = mk(9, 72'h57_1234_5678_CAFE_F00D, 0, 32'h0, 1, 1, 32'h1234_5678, 32'hCAFE_F00D, 4'hF, 1, 1, 40'h4B_0000_0000);
    vecs[4] = mk(1, {8'h13, 64'h0}, 0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 1, 40'h3F_0000_0000);
    vecs[5] = mk(5, {40'h52_FFFF_FFFC, 32'h0}, 0, 32'h0102_0304, 1, 1, 32'hFFFF_FFFC, 32'h0, 4'h0, 0, 5, 40'h4B_0102_0304);
    vecs[6] = mk(9, 72'h57_0000_0010_FFFF_FFFF, -1, 32'h0, 1, 8, 32'h0000_0010, 32'hFFFF_FFFF, 4'hF, 1, 1, 40'h45_0000_0000);
    vecs[7] = mk(1, {8'h72, 64'h0}, 0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 1, 40'h3F_0000_0000);
    // m_ready arrives on the very cycle the timeout would fire: ready must win.
    vecs[8] = mk(5, {40'h52_0000_0000, 32'h0}, 7, 32'h89AB_CDEF, 1, 8, 32'h0, 32'h0, 4'h0, 0, 5, 40'h4B_89AB_CDEF);

    // Reset state
    resetn = 1'b0;
    repeat (3) step();
    chk("rst_rx_ready", 64'(rx_ready), 64'(1'b0));
    chk("rst_tx_valid", 64'(tx_valid), 64'(1'b0));
    chk("rst_tx_data",  64'(tx_data),  64'(8'h00));
    chk("rst_m_valid",  64'(m_valid),  64'(1'b0));
    chk("rst_m_wstrb",  64'(m_wstrb),  64'(4'h0));
    chk("rst_m_addr",   64'(m_addr),   64'(32'h0));
    chk("rst_m_wdata",  64'(m_wdata),  64'(32'h0));
    chk("rst_busy",     64'(busy),     64'(1'b0));
    resetn = 1'b1;
    step();
    chk("idle_rx_ready", 64'(rx_ready), 64'(1'b1));

    // Table-driven command vectors
    tx_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      clear_logs();
      rsp_wait = vecs[i].wait_c;
      rsp_data = vecs[i].rdata;
      for (int k = 0; k < vecs[i].nb; k++) send_byte(vecs[i].cmd[71-8*k -: 8], 1'b0);
      wait_idle();
      chk($sformatf("v%0d_pulses", i), 64'(pc.size()), 64'(vecs[i].exp_pulses));
      if (vecs[i].exp_pulses > 0 && pc.size() > 0) begin
        chk($sformatf("v%0d_vcyc", i),  64'(pc[0]), 64'(vecs[i].exp_vcyc));
        chk($sformatf("v%0d_addr", i),  64'(pa[0]), 64'(vecs[i].exp_addr));
        chk($sformatf("v%0d_wstrb", i), 64'(ps[0]), 64'(vecs[i].exp_wstrb));
        if (vecs[i].chk_wdata) chk($sformatf("v%0d_wdata", i), 64'(pw[0]), 64'(vecs[i].exp_wdata));
      end
      chk($sformatf("v%0d_stable", i), 64'(stab_err), 64'(0));
      chk($sformatf("v%0d_ntx", i), 64'(txb.size()), 64'(vecs[i].exp_ntx));
      for (int j = 0; j < vecs[i].exp_ntx; j++) begin
        if (j < txb.size()) chk($sformatf("v%0d_tx%0d", i, j), 64'(txb[j]), 64'(vecs[i].exp_tx[39-8*j -: 8]));
      end
    end

    // Latency: last data byte at N -> m_valid at N+1, 'K' on tx at N+2
    clear_logs();
    rsp_wait = 0;
    begin
      logic [71:0] c;
      c = 72'h57_0300_0000_0000_0001;
      for (int k = 0; k < 8; k++) send_byte(c[71-8*k -: 8], 1'b0);
      chk("lat_pre_valid", 64'(m_valid), 64'(1'b0));
      send_byte(c[7:0], 1'b0);
      chk("lat_valid_n1", 64'(m_valid), 64'(1'b1));
      chk("lat_txv_n1", 64'(tx_valid), 64'(1'b0));
      step();
      chk("lat_txv_n2", 64'(tx_valid), 64'(1'b1));
      chk("lat_txd_n2", 64'(tx_data), 64'(8'h4B));
      chk("lat_valid_n2", 64'(m_valid), 64'(1'b0));
      wait_idle();
    end

    // Bad command under back-pressure
    clear_logs();
    tx_ready = 1'b0;
    send_byte(8'h13, 1'b0);
    begin
      int bad;
      bad = 0;
      for (int k = 0; k < 20; k++) begin
        if (tx_valid !== 1'b1 || tx_data !== 8'h3F || rx_ready !== 1'b0 || m_valid !== 1'b0) bad++;
        step();
      end
      chk("bp_stable_cycles_bad", 64'(bad), 64'(0));
    end
    tx_ready = 1'b1;
    wait_idle();
    chk("bp_ntx", 64'(txb.size()), 64'(1));
    if (txb.size() > 0) chk("bp_tx0", 64'(txb[0]), 64'(8'h3F));
    chk("bp_pulses", 64'(pc.size()), 64'(0));

    // Reset in the middle of a bus cycle
    clear_logs();
    rsp_wait = -1;
    begin
      logic [39:0] c;
      c = 40'h52_0300_0000;
      for (int k = 0; k < 5; k++) send_byte(c[39-8*k -: 8], 1'b0);
    end
    step();
    step();
    chk("rmb_valid_before", 64'(m_valid), 64'(1'b1));
    resetn = 1'b0;
    step();
    chk("rmb_m_valid", 64'(m_valid), 64'(1'b0));
    chk("rmb_tx_valid", 64'(tx_valid), 64'(1'b0));
    chk("rmb_busy", 64'(busy), 64'(1'b0));
    resetn = 1'b1;
    step();
    clear_logs();
    rsp_wait = 0;
    begin
      logic [71:0] c;
      c = 72'h57_0300_0000_0000_005A;
      for (int k = 0; k < 9; k++) send_byte(c[71-8*k -: 8], 1'b0);
    end
    wait_idle();
    chk("rmb_wr_ntx", 64'(txb.size()), 64'(1));
    if (txb.size() > 0) chk("rmb_wr_tx0", 64'(txb[0]), 64'(8'h4B));
    chk("rmb_wr_pulses", 64'(pc.size()), 64'(1));
    if (pc.size() > 0) chk("rmb_wr_wdata", 64'(pw[0]), 64'(32'h0000_005A));

    // Back-to-back: read streamed straight after a write, rx_valid held high
    clear_logs();
    rsp_wait = 0;
    rsp_data = 32'h0000_0077;
    begin
      logic [71:0] w;
      logic [39:0] r;
      int r_edge;
      w = 72'h57_0000_0020_0000_0055;
      r = 40'h52_0000_0020;
      for (int k = 0; k < 9; k++) send_byte(w[71-8*k -: 8], 1'b1);
      send_byte(r[39:32], 1'b1);
      r_edge = acc_edge;
      for (int k = 1; k < 5; k++) send_byte(r[39-8*k -: 8], 1'b1);
      rx_valid = 1'b0;
      wait_idle();
      chk("b2b_ntx", 64'(txb.size()), 64'(6));
      if (txe.size() > 0) chk("b2b_order", 64'(r_edge > txe[0]), 64'(1'b1));
      if (txb.size() == 6) begin
        chk("b2b_tx0", 64'(txb[0]), 64'(8'h4B));
        chk("b2b_tx1", 64'(txb[1]), 64'(8'h4B));
        chk("b2b_tx5", 64'(txb[5]), 64'(8'h77));
      end
      chk("b2b_pulses", 64'(pc.size()), 64'(2));
      if (pc.size() == 2) begin
        chk("b2b_w_addr",  64'(pa[0]), 64'(32'h0000_0020));
        chk("b2b_w_wdata", 64'(pw[0]), 64'(32'h0000_0055));
        chk("b2b_w_wstrb", 64'(ps[0]), 64'(4'hF));
        chk("b2b_r_addr",  64'(pa[1]), 64'(32'h0000_0020));
        chk("b2b_r_wstrb", 64'(ps[1]), 64'(4'h0));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
